rotary_quad_counter: RTL
========================

Name: rotary_quad_counter

Overview:
- Parametrised successor to the single-channel rotary-encoder LED counter.
- Synchronises and debounces the quadrature inputs Rot_A/Rot_B, then decodes every legal Gray-code transition as a 4x decoder.
- Accumulates sub-steps into detents and drives a CNT_W-bit up/down counter with wrap or saturate mode.
- Flags illegal transitions. Sits between the encoder pins and any consumer of the count (LED bar, menu logic).

Parameters:
- CNT_W, 6, width of Count.
- DEBOUNCE_CYC, 135000, consecutive stable cycles required before a debounced input changes; 0 means one-cycle qualification.
- SYNC_STAGES, 2, synchroniser flops per input; minimum 2.
- STEPS_PER_DETENT, 4, legal transitions per counted detent; legal values 1, 2, 4.
- SATURATE, 0, 0 = wrap modulo 2^CNT_W; 1 = clamp at 0 and 2^CNT_W-1.

Ports:
- Fg_Clk  in  1  system clock (27 MHz).
- RESET  in  1  asynchronous, active-high reset.
- Rot_A  in  1  raw encoder phase A, idle high.
- Rot_B  in  1  raw encoder phase B, idle high.
- Clear  in  1  synchronous clear of Count, accumulator and Err_Flag.
- Count  out  CNT_W  unsigned detent count.
- Step_CW  out  1  one-cycle pulse per clockwise detent.
- Step_CCW  out  1  one-cycle pulse per counter-clockwise detent.
- Dir  out  1  direction of last detent; 1 = CW.
- Err  out  1  one-cycle pulse on an illegal transition.
- Err_Flag  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (async, any time, including mid-rotation):
  - sync flops, debounce candidates and debounced A/B go to 1;
  - debounce counters, accumulator, Count, Step_CW, Step_CCW, Dir, Err and Err_Flag go to 0;
  - the previous-state register is loaded with 2'b11.
- Sync: SYNC_STAGES-deep shift chain per input.
- Debounce (per input): candidate register plus counter of width $clog2(DEBOUNCE_CYC+1).
  - Sync output != candidate: load candidate, counter <= 0.
  - Else, counter < DEBOUNCE_CYC: increment.
  - Else: debounced <= candidate.
  - Any glitch shorter than DEBOUNCE_CYC+1 cycles is discarded.
- Decode: register prev = {A,B}_debounced and compare it with the current debounced pair every cycle.
  - CW sequence: 11->10->00->01->11; each step gives +1.
  - CCW sequence: 11->01->00->10->11; each step gives -1.
  - No change gives 0.
  - Both bits changing (00<->11, 01<->10) is illegal: Err pulses, Err_Flag is set, the accumulator is cleared, Count is held.
- Accumulator: signed 4-bit.
  - On reaching +STEPS_PER_DETENT: clear to 0, pulse Step_CW, Dir <= 1, increment Count.
  - On reaching -STEPS_PER_DETENT: clear to 0, pulse Step_CCW, Dir <= 0, decrement Count.
  - A reversal mid-detent unwinds the accumulator and emits no pulse.
- Count arithmetic, unsigned CNT_W bits:
  - SATURATE=0: wraps (max+1 -> 0, 0-1 -> max).
  - SATURATE=1: holds at max on CW and at 0 on CCW. Step pulses and Dir still update at the limits.
- Timing: Count, Step_* and Dir update on the same edge. Latency from a raw input change (set up before edge 1) to the updated Count is SYNC_STAGES+DEBOUNCE_CYC+3 edges.
- Clear has priority over a same-cycle detent or error. Count, accumulator and Err_Flag go to 0; Step_*, Err are 0 that cycle; Dir is unchanged.
- Step_CW and Step_CCW are never high together.

Test Plan:
- Reset: assert RESET mid-rotation with Count=5 -> all outputs 0 immediately, without waiting for a clock edge; release, then idle 11 -> no pulses.
- CW detent (DEBOUNCE_CYC=4, SYNC_STAGES=2, STEPS=4): drive 11,10,00,01,11 with each state held 20 cycles -> exactly one Step_CW, 9 edges after the final raw 01->11; Count=1, Dir=1.
- Bounce: with DEBOUNCE_CYC=4 at idle, pulse Rot_A low for 3 cycles -> no Count change, no Err; low for 10 cycles then high -> accumulator returns to 0, no pulse.
- Wrap/saturate (CNT_W=4): SATURATE=0, Count=15 + CW detent -> 0, then CCW detent -> 15; SATURATE=1, Count=15 + CW -> 15 with Step_CW pulsed, Count=0 + CCW -> 0.
- Illegal: drive debounced 11->00 -> Err high 1 cycle, Err_Flag=1, Count held; then Clear -> Count=0, Err_Flag=0.
- Reversal and Clear collision: 11,10,00,10,11 -> no pulse, Count unchanged; assert Clear on the same edge as a CW detent -> Count=0, Step_CW=0.

Source files
------------

// File: rtl/rotary_quad_counter.sv
// rotary_quad_counter: synchronised, debounced 4x quadrature decoder driving an up/down detent counter.
// Revision 1.0
`default_nettype none

module rotary_quad_counter #(
   parameter int CNT_W            = 6,
   parameter int DEBOUNCE_CYC     = 135000,
   parameter int SYNC_STAGES      = 2,
   parameter int STEPS_PER_DETENT = 4,
   parameter int SATURATE         = 0
) (
   input  logic             Fg_Clk,
   input  logic             RESET,
   input  logic             Rot_A,
   input  logic             Rot_B,
   input  logic             Clear,
   output logic [CNT_W-1:0] Count,
   output logic             Step_CW,
   output logic             Step_CCW,
   output logic             Dir,
   output logic             Err,
   output logic             Err_Flag
);

   // A zero-cycle debounce still needs a one-bit counter to keep the datapath legal.
   localparam int DB_W = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
   localparam logic [DB_W-1:0]   DB_LIMIT = DB_W'(DEBOUNCE_CYC);
   localparam logic signed [3:0] ACC_POS  = 4'(STEPS_PER_DETENT);
   localparam logic signed [3:0] ACC_NEG  = -ACC_POS;

   logic [1:0] raw_w;
   logic [1:0] db_w;

   assign raw_w = {Rot_A, Rot_B};

   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   cand_q;
         logic [DB_W-1:0]        cnt_q;
         logic                   db_q;

         always_ff @(posedge Fg_Clk or posedge RESET) begin
            if (RESET) begin
               sync_q <= '1;
               cand_q <= 1'b1;
               cnt_q  <= '0;
               db_q   <= 1'b1;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], raw_w[i]};
               if (sync_q[SYNC_STAGES-1] != cand_q) begin
                  cand_q <= sync_q[SYNC_STAGES-1];
                  cnt_q  <= '0;
               end else if (cnt_q < DB_LIMIT) begin
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  db_q <= cand_q;
               end
            end
         end

         assign db_w[i] = db_q;
      end
   endgenerate

   logic [1:0]        prev_q;
   logic signed [3:0] acc_q;
   logic [CNT_W-1:0]  count_q;
   logic              step_cw_q;
   logic              step_ccw_q;
   logic              dir_q;
   logic              err_q;
   logic              err_flag_q;

   logic signed [3:0] delta_d;
   logic              illegal_d;
   logic signed [3:0] acc_sum_d;
   logic [CNT_W-1:0]  count_up_d;
   logic [CNT_W-1:0]  count_dn_d;

   always_comb begin
      delta_d   = 4'sd0;
      illegal_d = 1'b0;
      case ({prev_q, db_w})
         4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: delta_d   = 4'sd1;
         4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: delta_d   = -4'sd1;
         4'b11_00, 4'b00_11, 4'b01_10, 4'b10_01: illegal_d = 1'b1;
         default: ;
      endcase
      acc_sum_d = acc_q + delta_d;

      // Saturating mode pins the count at the rails; pulses and Dir still fire.
      if ((SATURATE != 0) && (count_q == '1)) count_up_d = count_q;
      else                                    count_up_d = count_q + 1'b1;
      if ((SATURATE != 0) && (count_q == '0)) count_dn_d = count_q;
      else                                    count_dn_d = count_q - 1'b1;
   end

   always_ff @(posedge Fg_Clk or posedge RESET) begin
      if (RESET) begin
         prev_q     <= 2'b11;
         acc_q      <= '0;
         count_q    <= '0;
         step_cw_q  <= 1'b0;
         step_ccw_q <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         prev_q     <= db_w;
         step_cw_q  <= 1'b0;
         step_ccw_q <= 1'b0;
         err_q      <= 1'b0;
         if (Clear) begin
            count_q    <= '0;
            acc_q      <= '0;
            err_flag_q <= 1'b0;
         end else if (illegal_d) begin
            err_q      <= 1'b1;
            err_flag_q <= 1'b1;
            acc_q      <= '0;
         end else if (acc_sum_d == ACC_POS) begin
            acc_q     <= '0;
            step_cw_q <= 1'b1;
            dir_q     <= 1'b1;
            count_q   <= count_up_d;
         end else if (acc_sum_d == ACC_NEG) begin
            acc_q      <= '0;
            step_ccw_q <= 1'b1;
            dir_q      <= 1'b0;
            count_q    <= count_dn_d;
         end else begin
            acc_q <= acc_sum_d;
         end
      end
   end

   assign Count    = count_q;
   assign Step_CW  = step_cw_q;
   assign Step_CCW = step_ccw_q;
   assign Dir      = dir_q;
   assign Err      = err_q;
   assign Err_Flag = err_flag_q;

endmodule

`default_nettype wire
